note_tone_gen: RTL and testbench
================================

# note_tone_gen

Converts the 5-bit note code produced by the music sequencer FSMs into a square-wave speaker drive. Sits between a sequencer's `out` bus and the audio output pin, in the same clock domain as the sequencer. The block tracks note changes, reloads its half-period divider on each change, and holds the output silent for the rest code. An optional articulation gap can be compiled in.

## Interface
- `CLK_HZ`, default 50_000_000: input clock frequency, used to compute the divider table.
- `REST_CODE`, default 31: note code that means silence.
- `GAP_CYCLES`, default 500_000: silent cycles inserted on a note change. Used only when `NOTE_TONE_GAP_EN` is defined.
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `note` in 5: note code from the sequencer, synchronous to `clk`, may change on any cycle.
- `speaker` out 1: square-wave drive.
- `active` out 1: high while a tone is being toggled out (state TONE).
- `note_strobe` out 1: one-cycle pulse on the cycle a note change is accepted.

## Operation
- Note mapping:
  - code n (0..30) maps to f(n) = 220 Hz × 2^(n/12).
  - Divider value is half(n) = round(CLK_HZ / (2·f(n))), computed at elaboration.
  - Counter width is W = $clog2(half(0)+1).
- Registers:
  - `note_q` (5b), `cnt` (W bits), `speaker`, and a state register.
  - `gap_cnt` is present only with the macro.
- States:
  - REST: `speaker`=0, `cnt`=0.
  - GAP: silent, `gap_cnt` counting. Exists only with the macro.
  - TONE: `cnt` counting, `speaker` toggling.
- Change detection: a change is `note != note_q` at a clock edge. On that edge:
  - `note_q` <= `note`.
  - `cnt` <= 0.
  - `speaker` <= 0.
  - `note_strobe` is asserted for that cycle.
  - Next state: REST if `note == REST_CODE`, otherwise TONE (or GAP with the macro).
- TONE, no change this edge:
  - If `cnt == half(note_q)-1`, then `cnt` <= 0 and `speaker` is inverted.
  - Otherwise `cnt` <= `cnt`+1.
- A change always takes priority over a divider terminal count on the same edge.
- Repeated identical codes are not a change: the tone continues phase-continuously.

## Timing
- Reset values, held while `rst`=1:
  - `note_q`=REST_CODE, state=REST, `cnt`=0, `speaker`=0, `active`=0, `note_strobe`=0.
- Reset asserted mid-tone forces `speaker` low asynchronously. There is no partial-cycle pulse after release.
- First cycle after reset release:
  - A `note` other than REST_CODE is treated as a change and is accepted on that first edge.
- Latency: with the change accepted at edge k, the first rising `speaker` edge occurs at edge k+half(n). The period is then exactly 2·half(n) cycles at 50 % duty.
- `note_strobe` and `active` are registered outputs. `active` rises on edge k (no gap).
- A change arriving in the middle of a half-period truncates it. The output goes low at once, so no pulse shorter than 1 cycle is ever produced.

## Configuration
- `NOTE_TONE_GAP_EN` defined:
  - A change to a non-rest code enters GAP with `gap_cnt`=0 for GAP_CYCLES cycles, with `speaker`=0 and `active`=0.
  - GAP then enters TONE with `cnt`=0. First rising edge at k+GAP_CYCLES+half(n).
  - A change during GAP restarts the gap with the new code. A change to REST_CODE during GAP goes to REST.
- Not defined: GAP state, `gap_cnt` and GAP_CYCLES logic are absent, and a change goes straight to TONE.

## Structure
- Package `music_pkg` holds:
  - the note code width (5);
  - the state enum {REST, GAP, TONE};
  - the constant function `half_period(n, clk_hz)`;
  - the base frequency constant 220.
- The sequencer FSMs' default rest code is also defined in `music_pkg`.
- One sub-module, `tone_divider`:
  - ports: clk, rst, load, half, en → tick;
  - contains the W-bit counter and terminal-count compare.
- The top module owns `note_q`, the FSM, the gap counter and the `speaker` flop.

## Test plan
1. Reset release, `note`=31 held, CLK_HZ=1_000_000 → `speaker`=0, `active`=0, no `note_strobe` for 10 000 cycles.
2. `note`=12 applied at edge k → `note_strobe` pulse at k; `speaker` rises at k+1136 and falls at k+2272. Period 2272 ±0 over 20 periods.
3. `note`=0 then 12 mid-half-period → `speaker` drops low at the change edge; new rise 1136 cycles later; no pulse shorter than 1 cycle.
4. `note` held 25 across repeated sequencer steps → no strobe; phase continuous (same edge spacing as a single long note).
5. `rst` pulsed mid-tone on note 18 → `speaker` low immediately; after release with `note`=18 re-accepted, first rise at +half(18).
6. With `NOTE_TONE_GAP_EN`, GAP_CYCLES=100, 0→12 change → `active`=0 for 100 cycles, first rise at k+100+1136. A second change at +50 restarts the gap.

Source files
------------

// File: rtl/music_pkg.sv
// Shared definitions for the music sequencer and tone generation blocks.
package music_pkg;

  localparam int unsigned NOTE_W = 5;

  // Default silence code driven by the sequencer FSMs.
  localparam logic [NOTE_W-1:0] SEQ_REST_CODE = 5'd31;

  // Frequency of note code 0, in Hz.
  localparam longint unsigned BASE_HZ = 64'd220;

  typedef enum logic [1:0] {
    REST = 2'd0,
    GAP  = 2'd1,
    TONE = 2'd2
  } tone_state_e;

  // round(clk_hz / (2 * BASE_HZ * 2^(n/12))), evaluated at elaboration.
  // Semitone ratios within an octave are held as 2^(k/12) scaled by 1e9.
  function automatic longint unsigned half_period(input int unsigned n,
                                                  input longint unsigned clk_hz);
    longint unsigned ratio;
    longint unsigned den;
    case (n % 12)
      0:       ratio = 64'd1_000_000_000;
      1:       ratio = 64'd1_059_463_094;
      2:       ratio = 64'd1_122_462_048;
      3:       ratio = 64'd1_189_207_115;
      4:       ratio = 64'd1_259_921_050;
      5:       ratio = 64'd1_334_839_854;
      6:       ratio = 64'd1_414_213_562;
      7:       ratio = 64'd1_498_307_077;
      8:       ratio = 64'd1_587_401_052;
      9:       ratio = 64'd1_681_792_831;
      10:      ratio = 64'd1_781_797_436;
      default: ratio = 64'd1_887_748_625;
    endcase
    den = (64'd2 * BASE_HZ * ratio) << (n / 12);
    return (clk_hz * 64'd1_000_000_000 + den / 64'd2) / den;
  endfunction

endpackage

// File: rtl/tone_divider.sv
// Half-period divider: counts enabled cycles and ticks on the terminal count.
// A load clears the counter and suppresses the tick on that edge.
module tone_divider #(
  parameter int unsigned W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] half,
  input  logic         en,
  output logic         tick
);

  logic [W-1:0] cnt;
  logic         term;

  assign term = (cnt == half - W'(1));
  assign tick = en && !load && term;

  // Counter: cleared by load, wraps to zero at half-1 while enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= term ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/note_tone_gen.sv
// Note code to square-wave speaker drive.
// Define NOTE_TONE_GAP_EN to insert GAP_CYCLES silent cycles on every change
// to a sounding note (articulation gap).
module note_tone_gen
  import music_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned REST_CODE  = 31,
  parameter int unsigned GAP_CYCLES = 500_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NOTE_W-1:0] note,
  output logic              speaker,
  output logic              active,
  output logic              note_strobe
);

  localparam logic [NOTE_W-1:0] RestCode  = NOTE_W'(REST_CODE);
  localparam int unsigned       NoteCodes = 1 << NOTE_W;
  // Note 0 has the longest half period and sets the counter width.
  localparam longint unsigned   Half0     = half_period(0, 64'(CLK_HZ));
  localparam int unsigned       W         = $clog2(Half0 + 64'd1);

  logic [NOTE_W-1:0] note_q;
  tone_state_e       state_q, state_d;
  logic              change;
  logic              gap_done;
  logic              load;
  logic              tick;
  logic [W-1:0]      half_tab [NoteCodes];
  logic [W-1:0]      half_sel;

  // Constant divider table, one entry per code.
  for (genvar g = 0; g < NoteCodes; g++) begin : g_half
    localparam longint unsigned H = half_period(g, 64'(CLK_HZ));
    assign half_tab[g] = W'(H);
  end

  assign half_sel = half_tab[note_q];
  assign change   = (note != note_q);

`ifdef NOTE_TONE_GAP_EN
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  logic [GapW-1:0] gap_cnt;

  assign gap_done = (state_q == GAP) && (gap_cnt == GapW'(GAP_CYCLES - 1));

  // Gap counter: restarts on every change, runs only while in GAP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_cnt <= '0;
    end else if (change) begin
      gap_cnt <= '0;
    end else if (state_q == GAP) begin
      gap_cnt <= gap_cnt + GapW'(1);
    end
  end
`else
  assign gap_done = 1'b0;
  // GAP_CYCLES has no effect without the articulation gap.
  if (GAP_CYCLES != 0) begin : g_no_gap
  end
`endif

  // Divider restarts from zero on every change and on entry to TONE.
  assign load = change || gap_done;

  tone_divider #(
    .W(W)
  ) u_div (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .half (half_sel),
    .en   (state_q == TONE),
    .tick (tick)
  );

  // Next state: a change always wins over gap expiry.
  always_comb begin
    state_d = state_q;
    if (change) begin
      if (note == RestCode) begin
        state_d = REST;
      end else begin
`ifdef NOTE_TONE_GAP_EN
        state_d = GAP;
`else
        state_d = TONE;
`endif
      end
    end else if (gap_done) begin
      state_d = TONE;
    end
  end

  // State, note latch and registered outputs; a change forces speaker low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= REST;
      note_q      <= RestCode;
      speaker     <= 1'b0;
      active      <= 1'b0;
      note_strobe <= 1'b0;
    end else begin
      state_q     <= state_d;
      active      <= (state_d == TONE);
      note_strobe <= change;
      if (change) begin
        note_q  <= note;
        speaker <= 1'b0;
      end else if (tick) begin
        speaker <= ~speaker;
      end
    end
  end

endmodule

// File: tb/tb_note_tone_gen.sv
// Scoreboard bench for note_tone_gen at CLK_HZ = 1 MHz.
// Half periods: note 0 -> 2273, 12 -> 1136, 14 -> 1012, 18 -> 804, 25 -> 536.
module tb_note_tone_gen;

  localparam logic [4:0] RestN = 5'd31;
`ifdef NOTE_TONE_GAP_EN
  localparam int GapLen = 100;
`else
  localparam int GapLen = 0;
`endif

  typedef enum logic [1:0] {EvStrobe, EvRise, EvFall} ev_e;
  typedef struct {
    ev_e kind;
    int  cyc;
  } ev_t;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic [4:0] note = RestN;
  logic       speaker, active, note_strobe;

  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_bad  = 0;
  ev_t  exp_q[$];
  logic prev_spk = 1'b0;

  // Expected-behaviour model state
  logic [4:0] cur_note     = RestN;
  int         cur_h        = 0;
  int         tone_k       = 0;
  int         pushed_until = 0;
  logic       exp_level    = 1'b0;

  note_tone_gen #(
    .CLK_HZ     (1_000_000),
    .REST_CODE  (31),
    .GAP_CYCLES (100)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .note        (note),
    .speaker     (speaker),
    .active      (active),
    .note_strobe (note_strobe)
  );

  always #5 clk = ~clk;

  // Edge counter: after edge k, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input ev_e k, input int c);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic check_lvl(input string name, input logic got, input logic want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %b, want %b", name, cyc, got, want);
    end
  endtask

  task automatic check_ev(input ev_e kind);
    ev_t e;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL event: got %s at cycle %0d, want nothing", kind.name(), cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.cyc != cyc) begin
        n_bad++;
        $display("FAIL event: got %s at cycle %0d, want %s at cycle %0d",
                 kind.name(), cyc, e.kind.name(), e.cyc);
      end
    end
  endtask

  // Monitor: every observed strobe and speaker edge is matched against the queue.
  always @(negedge clk) begin
    if (note_strobe) check_ev(EvStrobe);
    if (speaker && !prev_spk) check_ev(EvRise);
    if (!speaker && prev_spk) check_ev(EvFall);
    prev_spk <= speaker;
  end

  // Call just after an edge; the code is accepted on the next edge and held for len edges.
  task automatic start_note(input logic [4:0] n, input int h, input int len);
    int k;
    int t;
    bit changed;
    k       = cyc + 1;
    changed = (n != cur_note);
    if (changed) begin
      push(EvStrobe, k);
      if (exp_level) begin
        push(EvFall, k);
        exp_level = 1'b0;
      end
      cur_note     = n;
      cur_h        = h;
      tone_k       = k + GapLen;
      pushed_until = k;
    end
    if (n != RestN) begin
      for (int m = 1; tone_k + cur_h * m < k + len; m++) begin
        t = tone_k + cur_h * m;
        if (t > pushed_until) begin
          exp_level = !exp_level;
          push(exp_level ? EvRise : EvFall, t);
        end
      end
    end
    pushed_until = k + len - 1;
    note = n;
    for (int i = 0; i < len; i++) begin
      @(posedge clk);
      #1;
      if (changed && i == 0) check_lvl("active_at_change", active, n != RestN && GapLen == 0);
      if (changed && i == GapLen) check_lvl("active_after_gap", active, n != RestN);
    end
  endtask

  // Asynchronous reset pulse issued mid-cycle; call just after an edge.
  task automatic pulse_reset(input int hold);
    if (exp_level) begin
      push(EvFall, cyc);
      exp_level = 1'b0;
    end
    #1 rst = 1'b1;
    #1;
    check_lvl("rst_speaker", speaker, 1'b0);
    check_lvl("rst_active", active, 1'b0);
    check_lvl("rst_strobe", note_strobe, 1'b0);
    cur_note = RestN;
    repeat (hold) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_lvl("reset_speaker", speaker, 1'b0);
    check_lvl("reset_active", active, 1'b0);
    check_lvl("reset_strobe", note_strobe, 1'b0);
    #1 rst = 1'b0;

    // Rest code held after release: silent, no strobe.
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk);
      #1;
      if (i % 2500 == 0) begin
        check_lvl("rest_speaker", speaker, 1'b0);
        check_lvl("rest_active", active, 1'b0);
      end
    end

    // Note 12 for 20 periods.
    start_note(5'd12, 1136, 45800);

    // Note 0 then 12 while the speaker is high.
    start_note(5'd0, 2273, 3000);
    start_note(5'd12, 1136, 3000);

    // Note 25 rewritten every step: phase continuous, no strobe.
    for (int r = 0; r < 12; r++) start_note(5'd25, 536, 600);

    // Reset mid-tone on note 18, then re-acceptance.
    start_note(5'd18, 804, 1200);
    pulse_reset(3);
    start_note(5'd18, 804, 2000);

    // Quick successive changes (gap restart when compiled in).
    start_note(5'd0, 2273, 400);
    start_note(5'd12, 1136, 50);
    start_note(5'd14, 1012, 2500);
    start_note(RestN, 0, 20);

    repeat (5) @(posedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL pending_events: got %0d unobserved, want 0 (first %s at cycle %0d)",
               exp_q.size(), exp_q[0].kind.name(), exp_q[0].cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
